nv_nvdla_sdp_hls_x_op_feeder: RTL and testbench
===============================================

// Module: nv_nvdla_sdp_hls_x_op_feeder
// PURPOSE
//  Producer side of the X-stage operand interface. Consumes operand packets returned by the SDP DMA
//  read path and splits each one into independent ALU and MUL operand streams
//  (chn_alu_op/chn_mul_op, valid/ready). These streams are consumed by the x1/x2 int pipelines.
//  Supports per-element operands, and per-channel operands that are replayed over a surface.
//  The two streams drain independently, so each stream has its own small FIFO.
// PARAMETERS
//  TP        1  elements per beat (NVDLA_SDP_BS_THROUGHPUT); operand width per stream = 16*TP
//  FIFO_DEP  4  depth (beats) of each output FIFO; power of two, >=2
// PORTS
//  nvdla_core_clk       in   1       core clock
//  nvdla_core_rstn      in   1       async reset, active low
//  op_en                in   1       layer start pulse; sampled only in IDLE
//  cfg_alu_en           in   1       ALU operand stream enabled (alu_src = memory)
//  cfg_mul_en           in   1       MUL operand stream enabled (mul_src = memory)
//  cfg_per_chn          in   1       1: each packet is replayed cfg_repeat+1 times; 0: one push per packet
//  cfg_repeat           in   13      replay count minus one (surface size in beats minus 1)
//  cfg_beat_num         in   32      output beats per stream per layer, minus one
//  dma_rd_pvld          in   1       operand packet valid
//  dma_rd_prdy          out  1       operand packet ready
//  dma_rd_pd            in   32*TP   element i = bits[32i+31:32i] = {mul_op[15:0], alu_op[15:0]}
//  chn_alu_op_pvld      out  1       ALU operand valid
//  chn_alu_op_prdy      in   1       ALU operand ready
//  chn_alu_op           out  16*TP   ALU operands, element i at [16i+15:16i]
//  chn_mul_op_pvld      out  1       MUL operand valid
//  chn_mul_op_prdy      in   1       MUL operand ready
//  chn_mul_op           out  16*TP   MUL operands, element i at [16i+15:16i]
//  op_done              out  1       one-cycle pulse: layer fully delivered and both FIFOs empty
// BEHAVIOUR
//  Reset values: dma_rd_prdy=0, both pvld=0, op_done=0, both FIFOs empty, hold register empty, FSM=IDLE.
//  Data outputs are 0 after reset and don't-care while their pvld=0.
//  FSM states
//   - IDLE:  op_en moves to RUN; counters load (push_cnt=0, rep_cnt=0).
//   - RUN:   the last push (push_cnt==cfg_beat_num) moves to DRAIN.
//   - DRAIN: when both FIFOs are empty -> IDLE, op_done=1 for exactly that cycle.
//   - op_en in RUN or DRAIN is ignored.
//   - cfg_* are static from op_en until op_done.
//  Hold register
//   - Captures dma_rd_pd on dma_rd_pvld&dma_rd_prdy.
//   - A "push" writes hold[alu half] into the ALU FIFO if cfg_alu_en, and hold[mul half] into the
//     MUL FIFO if cfg_mul_en, in the same cycle.
//   - Push condition: RUN & hold full & every enabled FIFO has space.
//   - All-or-nothing: neither FIFO is written unless both enabled FIFOs have space.
//  Replay
//   - cfg_per_chn=0: hold empties on its push.
//   - cfg_per_chn=1: hold stays full; rep_cnt increments on each push. On the push with
//     rep_cnt==cfg_repeat, hold empties and rep_cnt=0.
//  dma_rd_prdy = RUN & (hold empty | releasing push this cycle) & packet still needed.
//  Back-to-back packets therefore sustain 1 beat/clk.
//  push_cnt increments per push. No further packets are accepted once the last push has occurred.
//  Latency: a push in cycle N is visible at the FIFO head (pvld=1) in cycle N+1; no combinational in->out path.
//  Streams are fully independent. A stalled MUL consumer stalls pushes only via FIFO-full and never
//  corrupts ALU order. A disabled stream keeps pvld=0 and its FIFO untouched.
//  If both cfg_alu_en and cfg_mul_en are 0: RUN goes straight to DRAIN, then op_done; dma_rd_prdy stays 0.
//  FIFO pointers wrap modulo FIFO_DEP. Full and empty are distinguished by an extra pointer wrap bit.
//  Read and write of a full FIFO in the same cycle are both allowed; count is unchanged.
//  Reset mid-layer: all state, FIFOs and counters clear immediately (async). Nothing is emitted afterwards.
// TESTING
//  1. TP=1, both enabled, per_chn=0, beat_num=3, packets 0x0002_0001..0x0008_0007, consumers always ready
//     -> alu 1,3,5,7 and mul 2,4,6,8 at 1/clk; op_done one cycle after last beat is popped.
//  2. per_chn=1, repeat=2, beat_num=5, 2 packets {0xB,0xA},{0xD,0xC}
//     -> alu A,A,A,C,C,C; mul B,B,B,D,D,D; exactly 2 dma handshakes.
//  3. mul_prdy held 0, alu_prdy=1, FIFO_DEP=4
//     -> after 4 pushes dma_rd_prdy=0 and alu stops after 4 beats.
//     -> releasing mul_prdy resumes both streams in order with no loss or duplication.
//  4. cfg_alu_en=1, cfg_mul_en=0 -> mul_pvld never asserts; alu stream complete; op_done fires.
//     Also with both disabled: op_done 2 cycles after op_en and no dma handshake.
//  5. Random pvld/prdy stalls on all three ports, 1000 beats
//     -> scoreboard exact order per stream, and FIFO never overflows.
//     op_en pulsed during RUN is ignored.
//  6. Assert nvdla_core_rstn mid-layer with FIFOs full
//     -> all pvld/prdy/op_done 0 same cycle; a new op_en afterwards runs a clean layer.

Source files
------------

// File: rtl/nv_nvdla_sdp_hls_x_op_feeder.sv
// X-stage operand feeder: splits DMA operand packets into independent ALU and MUL
// operand streams, with optional per-channel replay and a per-stream output FIFO.

module nv_nvdla_sdp_hls_x_op_fifo #(
  parameter int W   = 16,
  parameter int DEP = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rd_data,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = $clog2(DEP);

  logic [W-1:0] r_mem [DEP];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_wr;
  logic         w_rd;

  // The extra MSB on each pointer separates full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd      = i_rd_en & ~o_empty;
  assign w_wr      = i_wr_en & (~o_full | w_rd);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEP; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// state    | meaning
// ST_IDLE  | waiting for op_en; counters reload on start
// ST_RUN   | accepting packets and pushing operands into the FIFOs
// ST_DRAIN | all pushes done; waiting for both FIFOs to empty, then op_done
module nv_nvdla_sdp_hls_x_op_feeder #(
  parameter int TP       = 1,
  parameter int FIFO_DEP = 4
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             op_en,
  input  logic             cfg_alu_en,
  input  logic             cfg_mul_en,
  input  logic             cfg_per_chn,
  input  logic [12:0]      cfg_repeat,
  input  logic [31:0]      cfg_beat_num,
  input  logic             dma_rd_pvld,
  output logic             dma_rd_prdy,
  input  logic [32*TP-1:0] dma_rd_pd,
  output logic             chn_alu_op_pvld,
  input  logic             chn_alu_op_prdy,
  output logic [16*TP-1:0] chn_alu_op,
  output logic             chn_mul_op_pvld,
  input  logic             chn_mul_op_prdy,
  output logic [16*TP-1:0] chn_mul_op,
  output logic             op_done
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [32*TP-1:0]  r_hold;
  logic              r_hold_vld;
  logic [31:0]       r_push_cnt;
  logic [12:0]       r_rep_cnt;
  logic [16*TP-1:0]  w_hold_alu;
  logic [16*TP-1:0]  w_hold_mul;
  logic              w_alu_empty;
  logic              w_alu_full;
  logic              w_mul_empty;
  logic              w_mul_full;
  logic              w_run;
  logic              w_any_en;
  logic              w_push;
  logic              w_last_push;
  logic              w_release;
  logic              w_accept;
  logic              w_start;

  for (genvar g = 0; g < TP; g++) begin : g_split
    assign w_hold_alu[16*g +: 16] = r_hold[32*g      +: 16];
    assign w_hold_mul[16*g +: 16] = r_hold[32*g + 16 +: 16];
  end

  assign w_run    = (r_state == ST_RUN);
  assign w_start  = (r_state == ST_IDLE) & op_en;
  assign w_any_en = cfg_alu_en | cfg_mul_en;

  // All-or-nothing: a push waits until every enabled FIFO can take it.
  assign w_push      = w_run & r_hold_vld & w_any_en &
                       (~cfg_alu_en | ~w_alu_full) & (~cfg_mul_en | ~w_mul_full);
  assign w_last_push = w_push & (r_push_cnt == cfg_beat_num);
  assign w_release   = w_push & (~cfg_per_chn | (r_rep_cnt == cfg_repeat));

  assign dma_rd_prdy = w_run & w_any_en & (~r_hold_vld | w_release) & ~w_last_push;
  assign w_accept    = dma_rd_pvld & dma_rd_prdy;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (w_accept) begin
      r_hold     <= dma_rd_pd;
      r_hold_vld <= 1'b1;
    end else if (w_release || w_last_push || !w_run) begin
      // A layer can end mid-replay; the leftover packet is dropped.
      r_hold_vld <= 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_push_cnt <= '0;
      r_rep_cnt  <= '0;
    end else if (w_start) begin
      r_push_cnt <= '0;
      r_rep_cnt  <= '0;
    end else if (w_push) begin
      r_push_cnt <= r_push_cnt + 32'd1;
      if (cfg_per_chn && (r_rep_cnt != cfg_repeat)) r_rep_cnt <= r_rep_cnt + 13'd1;
      else                                          r_rep_cnt <= '0;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) r_state <= ST_IDLE;
    else                  r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    op_done     = 1'b0;
    case (r_state)
      ST_IDLE:  if (op_en) w_state_nxt = ST_RUN;
      ST_RUN:   if (!w_any_en || w_last_push) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (w_alu_empty && w_mul_empty) begin
          w_state_nxt = ST_IDLE;
          op_done     = 1'b1;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  nv_nvdla_sdp_hls_x_op_fifo #(.W(16*TP), .DEP(FIFO_DEP)) u_alu_fifo (
    .clk       (nvdla_core_clk),
    .rst_n     (nvdla_core_rstn),
    .i_wr_en   (w_push & cfg_alu_en),
    .i_wr_data (w_hold_alu),
    .i_rd_en   (chn_alu_op_prdy),
    .o_rd_data (chn_alu_op),
    .o_empty   (w_alu_empty),
    .o_full    (w_alu_full)
  );

  nv_nvdla_sdp_hls_x_op_fifo #(.W(16*TP), .DEP(FIFO_DEP)) u_mul_fifo (
    .clk       (nvdla_core_clk),
    .rst_n     (nvdla_core_rstn),
    .i_wr_en   (w_push & cfg_mul_en),
    .i_wr_data (w_hold_mul),
    .i_rd_en   (chn_mul_op_prdy),
    .o_rd_data (chn_mul_op),
    .o_empty   (w_mul_empty),
    .o_full    (w_mul_full)
  );

  assign chn_alu_op_pvld = ~w_alu_empty;
  assign chn_mul_op_pvld = ~w_mul_empty;
endmodule

// File: tb/tb_nv_nvdla_sdp_hls_x_op_feeder.sv
// Scoreboard bench for the X-stage operand feeder: expected operands are queued per
// stream at layer start and popped by a monitor on every output handshake.

module tb_nv_nvdla_sdp_hls_x_op_feeder;
  localparam int TP       = 1;
  localparam int FIFO_DEP = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        op_en = 1'b0;
  logic        cfg_alu_en = 1'b0, cfg_mul_en = 1'b0, cfg_per_chn = 1'b0;
  logic [12:0] cfg_repeat = '0;
  logic [31:0] cfg_beat_num = '0;
  logic        dma_rd_pvld = 1'b0;
  logic        dma_rd_prdy;
  logic [31:0] dma_rd_pd = '0;
  logic        alu_pvld, mul_pvld;
  logic        alu_prdy = 1'b0, mul_prdy = 1'b0;
  logic [15:0] alu_op, mul_op;
  logic        op_done;

  always #5 clk = ~clk;

  nv_nvdla_sdp_hls_x_op_feeder #(.TP(TP), .FIFO_DEP(FIFO_DEP)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .op_en           (op_en),
    .cfg_alu_en      (cfg_alu_en),
    .cfg_mul_en      (cfg_mul_en),
    .cfg_per_chn     (cfg_per_chn),
    .cfg_repeat      (cfg_repeat),
    .cfg_beat_num    (cfg_beat_num),
    .dma_rd_pvld     (dma_rd_pvld),
    .dma_rd_prdy     (dma_rd_prdy),
    .dma_rd_pd       (dma_rd_pd),
    .chn_alu_op_pvld (alu_pvld),
    .chn_alu_op_prdy (alu_prdy),
    .chn_alu_op      (alu_op),
    .chn_mul_op_pvld (mul_pvld),
    .chn_mul_op_prdy (mul_prdy),
    .chn_mul_op      (mul_op),
    .op_done         (op_done)
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int alu_mode = 0, mul_mode = 0;  // 0 always ready, 1 random, 2 held low
  int hs_cnt, done_cnt, done_cyc, last_pop_cyc;
  int alu_pops, mul_pops, alu_pvld_seen, mul_pvld_seen;
  bit abort = 1'b0;
  logic [31:0] pkts[$];
  logic [15:0] exp_alu[$], exp_mul[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    alu_prdy = (alu_mode == 0) ? 1'b1 : (alu_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    mul_prdy = (mul_mode == 0) ? 1'b1 : (mul_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Monitor: independent of stimulus, pops the expected queues on each output handshake.
  always @(negedge clk) begin
    if (rstn) begin
      if (alu_pvld) alu_pvld_seen++;
      if (mul_pvld) mul_pvld_seen++;
      if (alu_pvld && alu_prdy) begin
        check("alu_expected_avail", exp_alu.size() > 0, 1);
        if (exp_alu.size() > 0) check("alu_data", alu_op, exp_alu.pop_front());
        alu_pops++;
        last_pop_cyc = cyc;
      end
      if (mul_pvld && mul_prdy) begin
        check("mul_expected_avail", exp_mul.size() > 0, 1);
        if (exp_mul.size() > 0) check("mul_data", mul_op, exp_mul.pop_front());
        mul_pops++;
        last_pop_cyc = cyc;
      end
      if (dma_rd_pvld && dma_rd_prdy) hs_cnt++;
      if (op_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic feed(input int npk, input bit rnd);
    int i = 0;
    int guard = 0;
    bit hs;
    while (i < npk && guard < 10000 && !abort) begin
      dma_rd_pvld = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      dma_rd_pd   = pkts[i];
      @(negedge clk);
      hs = dma_rd_pvld && dma_rd_prdy;
      @(posedge clk);
      #1;
      if (hs) i++;
      guard++;
    end
    dma_rd_pvld = 1'b0;
  endtask

  task automatic run_layer(input bit a_en, input bit m_en, input bit pc, input int rep,
                           input int bn, input bit rnd, input int hold_mul,
                           input bit mid_pulse, output int start);
    int npk;
    int idx;
    cfg_alu_en   = a_en;
    cfg_mul_en   = m_en;
    cfg_per_chn  = pc;
    cfg_repeat   = 13'(rep);
    cfg_beat_num = 32'(bn);
    for (int k = 0; k <= bn; k++) begin
      idx = pc ? k / (rep + 1) : k;
      if (a_en) exp_alu.push_back(pkts[idx][15:0]);
      if (m_en) exp_mul.push_back(pkts[idx][31:16]);
    end
    npk = (!a_en && !m_en) ? 0 : (pc ? bn / (rep + 1) + 1 : bn + 1);
    hs_cnt = 0; done_cnt = 0; done_cyc = 0; alu_pops = 0; mul_pops = 0;
    alu_pvld_seen = 0; mul_pvld_seen = 0;
    if (hold_mul > 0) mul_mode = 2;
    @(posedge clk); #1;
    op_en = 1'b1;
    start = cyc;
    @(posedge clk); #1;
    op_en = 1'b0;
    fork
      feed(npk, rnd);
      begin
        int t = 0;
        while (done_cnt == 0 && t < 10000) begin
          @(posedge clk);
          t++;
        end
      end
      if (hold_mul > 0) begin
        repeat (hold_mul) @(posedge clk);
        @(negedge clk);
        check("mulstall_dma_prdy", dma_rd_prdy, 0);
        check("mulstall_alu_pops", alu_pops, FIFO_DEP);
        check("mulstall_mul_pops", mul_pops, 0);
        check("mulstall_dma_hs", hs_cnt, FIFO_DEP + 1);
        mul_mode = 0;
      end
      if (mid_pulse) begin
        repeat (20) @(posedge clk);
        #1 op_en = 1'b1;
        @(posedge clk);
        #1 op_en = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("op_done_count", done_cnt, 1);
    check("dma_handshakes", hs_cnt, npk);
    check("alu_left_over", exp_alu.size(), 0);
    check("mul_left_over", exp_mul.size(), 0);
    exp_alu.delete();
    exp_mul.delete();
  endtask

  initial begin
    int s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dma_prdy", dma_rd_prdy, 0);
    check("rst_alu_pvld", alu_pvld, 0);
    check("rst_mul_pvld", mul_pvld, 0);
    check("rst_op_done", op_done, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_mul_op", mul_op, 0);
    rstn = 1'b1;

    // 1: plain streaming, both enabled
    pkts.delete();
    for (int i = 0; i < 4; i++) pkts.push_back({16'(2 * i + 2), 16'(2 * i + 1)});
    run_layer(1, 1, 0, 0, 3, 0, 0, 0, s);
    check("t1_done_latency", done_cyc - s, 7);
    check("t1_done_after_last_pop", done_cyc - last_pop_cyc, 1);
    check("t1_alu_pops", alu_pops, 4);

    // 2: per-channel replay
    pkts.delete();
    pkts.push_back(32'h000B_000A);
    pkts.push_back(32'h000D_000C);
    run_layer(1, 1, 1, 2, 5, 0, 0, 0, s);
    check("t2_alu_pops", alu_pops, 6);

    // 3: MUL consumer stalled, FIFO-full backpressure
    pkts.delete();
    for (int i = 0; i < 8; i++) pkts.push_back({16'(16'h100 + i), 16'(16'h200 + i)});
    run_layer(1, 1, 0, 0, 7, 0, 14, 0, s);
    check("t3_mul_pops", mul_pops, 8);

    // 4: MUL disabled, then both disabled
    pkts.delete();
    for (int i = 0; i < 6; i++) pkts.push_back({16'(16'hE0 + i), 16'(16'h30 + i)});
    run_layer(1, 0, 0, 0, 5, 0, 0, 0, s);
    check("t4_mul_pvld_never", mul_pvld_seen, 0);
    check("t4_alu_pops", alu_pops, 6);
    run_layer(0, 0, 0, 0, 5, 0, 0, 0, s);
    check("t4b_done_latency", done_cyc - s, 2);
    check("t4b_alu_pvld_never", alu_pvld_seen, 0);

    // 5: random stalls everywhere, op_en re-pulsed during RUN
    pkts.delete();
    for (int i = 0; i < 1000; i++) pkts.push_back($urandom);
    alu_mode = 1; mul_mode = 1;
    run_layer(1, 1, 0, 0, 999, 1, 0, 1, s);
    check("t5_alu_pops", alu_pops, 1000);
    check("t5_mul_pops", mul_pops, 1000);
    pkts.delete();
    for (int i = 0; i < 40; i++) pkts.push_back($urandom);
    run_layer(1, 1, 1, 3, 150, 1, 0, 0, s);
    check("t5b_mul_pops", mul_pops, 151);
    alu_mode = 0; mul_mode = 0;

    // 6: reset mid-layer with FIFOs full
    pkts.delete();
    for (int i = 0; i < 10; i++) pkts.push_back({16'(16'h50 + i), 16'(16'h60 + i)});
    alu_mode = 2; mul_mode = 2;
    cfg_alu_en = 1; cfg_mul_en = 1; cfg_per_chn = 0; cfg_repeat = '0; cfg_beat_num = 32'd9;
    @(posedge clk); #1 op_en = 1'b1;
    @(posedge clk); #1 op_en = 1'b0;
    abort = 1'b0;
    fork
      feed(10, 0);
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t6_alu_pvld_before_rst", alu_pvld, 1);
        check("t6_dma_prdy_before_rst", dma_rd_prdy, 0);
        #1 rstn = 1'b0;
        #1;
        check("t6_rst_alu_pvld", alu_pvld, 0);
        check("t6_rst_mul_pvld", mul_pvld, 0);
        check("t6_rst_dma_prdy", dma_rd_prdy, 0);
        check("t6_rst_op_done", op_done, 0);
        abort = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    alu_mode = 0; mul_mode = 0;
    alu_pops = 0; mul_pops = 0; done_cnt = 0;
    #3 rstn = 1'b1;
    abort = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t6_no_alu_after_rst", alu_pops, 0);
    check("t6_no_mul_after_rst", mul_pops, 0);
    check("t6_no_done_after_rst", done_cnt, 0);
    pkts.delete();
    for (int i = 0; i < 5; i++) pkts.push_back({16'(16'h70 + i), 16'(16'h80 + i)});
    run_layer(1, 1, 0, 0, 4, 0, 0, 0, s);
    check("t6_clean_alu_pops", alu_pops, 5);
    check("t6_clean_done_latency", done_cyc - s, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
